// File: rtl/rtc_bus_pkg.sv
// Shared types and timing defaults for the RTC bus sequencer.
// Imported by the sequencer top and its phase timer.
package rtc_bus_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    A_SU = 4'd1,
    A_PW = 4'd2,
    A_HD = 4'd3,
    GAP  = 4'd4,
    D_SU = 4'd5,
    D_PW = 4'd6,
    D_HD = 4'd7,
    DONE = 4'd8
  } state_t;

  localparam int T_SU_DEF  = 2;
  localparam int T_PW_DEF  = 5;
  localparam int T_HD_DEF  = 2;
  localparam int T_GAP_DEF = 2;
  localparam int CW_DEF    = 4;

  localparam logic ADDR_PHASE = 1'b0;
  localparam logic DATA_PHASE = 1'b1;

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down counter timing one sequencer phase.
// last is high on the final cycle of the loaded phase.
module rtc_phase_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          last
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Multiplexed address/data bus sequencer for the external RTC.
// Outputs are registered from the next state so strobes never glitch.
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int T_SU  = T_SU_DEF,
  parameter int T_PW  = T_PW_DEF,
  parameter int T_HD  = T_HD_DEF,
  parameter int T_GAP = T_GAP_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_wr,
  input  logic       start_rd,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] RTC_out,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       A_D,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data
);

  localparam logic [CW-1:0] L_SU  = CW'(T_SU - 1);
  localparam logic [CW-1:0] L_PW  = CW'(T_PW - 1);
  localparam logic [CW-1:0] L_HD  = CW'(T_HD - 1);
  localparam logic [CW-1:0] L_GAP = CW'(T_GAP - 1);

  state_t        state, nxt;
  logic          is_wr;
  logic [7:0]    a_q, d_q;
  logic          last, load;
  logic [CW-1:0] lval;

  // Entry into A_SU happens from IDLE, before the latches update.
  logic       wr_n;
  logic [7:0] a_n, d_n;
  assign wr_n = (state == IDLE) ? start_wr : is_wr;
  assign a_n  = (state == IDLE) ? addr : a_q;
  assign d_n  = (state == IDLE) ? wdata : d_q;

  rtc_phase_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (lval),
    .last     (last)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start_wr || start_rd) nxt = A_SU;
      A_SU: if (last) nxt = A_PW;
      A_PW: if (last) nxt = A_HD;
      A_HD: if (last) nxt = GAP;
      GAP:  if (last) nxt = D_SU;
      D_SU: if (last) nxt = D_PW;
      D_PW: if (last) nxt = D_HD;
      D_HD: if (last) nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    load = (nxt != state);
    lval = '0;
    unique case (nxt)
      A_SU, D_SU: lval = L_SU;
      A_PW, D_PW: lval = L_PW;
      A_HD, D_HD: lval = L_HD;
      GAP:        lval = L_GAP;
      default:    lval = '0;
    endcase
  end

  logic       ad_d, cs_d, rd_d, wr_d, oe_d;
  logic [7:0] bus_d;

  always_comb begin
    ad_d  = DATA_PHASE;
    cs_d  = 1'b1;
    rd_d  = 1'b1;
    wr_d  = 1'b1;
    oe_d  = 1'b0;
    bus_d = 8'h00;
    unique case (nxt)
      A_SU, A_HD: begin
        ad_d  = ADDR_PHASE;
        oe_d  = 1'b1;
        bus_d = a_n;
      end
      A_PW: begin
        ad_d  = ADDR_PHASE;
        oe_d  = 1'b1;
        bus_d = a_n;
        cs_d  = 1'b0;
        wr_d  = 1'b0;
      end
      D_SU, D_HD: begin
        oe_d  = wr_n;
        bus_d = wr_n ? d_n : 8'h00;
      end
      D_PW: begin
        cs_d  = 1'b0;
        oe_d  = wr_n;
        bus_d = wr_n ? d_n : 8'h00;
        wr_d  = ~wr_n;
        rd_d  = wr_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      is_wr   <= 1'b0;
      a_q     <= 8'h00;
      d_q     <= 8'h00;
      A_D     <= DATA_PHASE;
      CS      <= 1'b1;
      RD      <= 1'b1;
      WR      <= 1'b1;
      bus_oe  <= 1'b0;
      bus_out <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_data <= 8'h00;
    end else begin
      state   <= nxt;
      is_wr   <= wr_n;
      a_q     <= a_n;
      d_q     <= d_n;
      A_D     <= ad_d;
      CS      <= cs_d;
      RD      <= rd_d;
      WR      <= wr_d;
      bus_oe  <= oe_d;
      bus_out <= bus_d;
      busy    <= (nxt != IDLE);
      done    <= (nxt == DONE);
      if (state == D_PW && last && !is_wr) begin
        rd_data <= RTC_out;
      end
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: per-cycle check of every
// output against the documented cycle table.
module tb_rtc_bus_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_wr, start_rd;
  logic [7:0] addr, wdata, RTC_out;
  logic [7:0] bus_out, rd_data;
  logic       bus_oe, A_D, CS, RD, WR, busy, done;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] exp_rdd;

  rtc_bus_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .start_wr(start_wr),
    .start_rd(start_rd),
    .addr    (addr),
    .wdata   (wdata),
    .RTC_out (RTC_out),
    .bus_out (bus_out),
    .bus_oe  (bus_oe),
    .A_D     (A_D),
    .CS      (CS),
    .RD      (RD),
    .WR      (WR),
    .busy    (busy),
    .done    (done),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag,
                           input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Packed view: busy,done,A_D,CS,RD,WR,oe,bus,rd_data
  function automatic logic [31:0] obs();
    logic [7:0] b;
    b = bus_oe ? bus_out : 8'h00;
    return {9'b0, busy, done, A_D, CS, RD, WR, bus_oe, b, rd_data};
  endfunction

  // View v = outputs sampled at edge v after the start edge 0.
  function automatic logic [31:0] exp_view(input int v, input bit w,
                                           input logic [7:0] a,
                                           input logic [7:0] d,
                                           input logic [7:0] rdd);
    logic bz, dn, ad, cs, rd, wr, oe;
    logic [7:0] b;
    {bz, dn, ad, cs, rd, wr, oe} = 7'b0011110;
    b = 8'h00;
    if (v >= 1 && v <= 21) bz = 1'b1;
    if (v >= 1 && v <= 9) begin
      ad = 1'b0;
      oe = 1'b1;
      b  = a;
    end
    if (v >= 3 && v <= 7) begin
      cs = 1'b0;
      wr = 1'b0;
    end
    if (w && v >= 12 && v <= 20) begin
      oe = 1'b1;
      b  = d;
    end
    if (v >= 14 && v <= 18) begin
      cs = 1'b0;
      if (w) wr = 1'b0;
      else   rd = 1'b0;
    end
    if (v == 21) dn = 1'b1;
    return {9'b0, bz, dn, ad, cs, rd, wr, oe, b, rdd};
  endfunction

  task automatic run_txn(input int tn, input bit wr, input bit rd,
                         input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] r1, input logic [7:0] r2,
                         input int inj, input int rst_at,
                         input bit b2b, input int n);
    int v;
    bit iw;
    logic [7:0] rtc;
    @(negedge clk);
    start_wr = wr;
    start_rd = rd;
    addr     = a;
    wdata    = d;
    for (int i = 1; i <= n; i++) begin
      if (rst_at > 0 && i > rst_at) begin
        v = 0;
      end else if (b2b && i > 22) begin
        v = i - 22;
      end else begin
        v = (i > 21) ? 0 : i;
      end
      iw  = (b2b && i > 22) ? 1'b0 : wr;
      rtc = (b2b && i > 22) ? r2 : r1;
      @(posedge clk);
      #1;
      start_wr = 1'b0;
      start_rd = (i == inj) || (b2b && i == 22);
      reset    = (i == rst_at) ? 1'b0 : 1'b1;
      RTC_out  = (v >= 14 && v <= 18) ? rtc : 8'hEE;
      @(negedge clk);
      if (!iw && v == 19) exp_rdd = rtc;
      if (rst_at > 0 && i == rst_at + 1) exp_rdd = 8'h00;
      check_vec($sformatf("t%0d v%0d", tn, i), obs(),
                exp_view(v, iw, a, d, exp_rdd));
    end
    start_rd = 1'b0;
    reset    = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    start_wr = 1'b0;
    start_rd = 1'b0;
    addr     = 8'h00;
    wdata    = 8'h00;
    RTC_out  = 8'hEE;
    exp_rdd  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_vec("reset", obs(), exp_view(0, 1'b0, 8'h00, 8'h00, 8'h00));
    reset = 1'b1;
    // write
    run_txn(1, 1'b1, 1'b0, 8'h21, 8'h45, 8'h00, 8'h00, 0, 0, 1'b0, 26);
    // read
    run_txn(2, 1'b0, 1'b1, 8'h22, 8'h00, 8'h59, 8'h00, 0, 0, 1'b0, 26);
    // simultaneous starts: write wins
    run_txn(3, 1'b1, 1'b1, 8'h10, 8'h33, 8'hC3, 8'h00, 0, 0, 1'b0, 24);
    // start_rd mid-write ignored
    run_txn(4, 1'b1, 1'b0, 8'h30, 8'hA5, 8'h3C, 8'h00, 5, 0, 1'b0, 30);
    // reset during read D_PW
    run_txn(5, 1'b0, 1'b1, 8'h40, 8'h00, 8'h7E, 8'h00, 0, 16, 1'b0, 24);
    // clean read after abort
    run_txn(6, 1'b0, 1'b1, 8'h41, 8'h00, 8'h6C, 8'h00, 0, 0, 1'b0, 24);
    // back-to-back reads, second start at edge 22
    run_txn(7, 1'b0, 1'b1, 8'h50, 8'h00, 8'h11, 8'h99, 0, 0, 1'b1, 46);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
